// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// master drives payload/ready/flush; slave is the stage register.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
);
  logic              flush_in;
  logic              up_valid_in;
  logic              up_ready_out;
  logic [DATA_W-1:0] up_data_in;
  logic              dn_valid_out;
  logic              dn_ready_in;
  logic [DATA_W-1:0] dn_data_out;
  logic [1:0]        occupancy_out;
  logic [CNT_W-1:0]  bubble_cnt_out;

  modport master (
    output flush_in,
    output up_valid_in,
    output up_data_in,
    output dn_ready_in,
    input  up_ready_out,
    input  dn_valid_out,
    input  dn_data_out,
    input  occupancy_out,
    input  bubble_cnt_out
  );

  modport slave (
    input  flush_in,
    input  up_valid_in,
    input  up_data_in,
    input  dn_ready_in,
    output up_ready_out,
    output dn_valid_out,
    output dn_data_out,
    output occupancy_out,
    output bubble_cnt_out
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with optional skid entry, flush and
// saturating bubble counter.
// Ports: clk_in, rst_in (sync, active-high); bus (slave): flush_in,
//   up_valid_in/up_ready_out/up_data_in, dn_valid_out/dn_ready_in/
//   dn_data_out, occupancy_out (0/1/2), bubble_cnt_out.
module pipe_skid_reg #(
  parameter int                 DATA_W    = 160,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  bub_q, bub_d;

  logic up_ready;
  logic dn_valid;
  logic up_fire;
  logic dn_fire;

  // With the skid entry, ready depends only on the state register,
  // which breaks the ready path between neighbouring stages.
  generate
    if (SKID != 0) begin : g_skid
      assign up_ready = (state_q != FULL);
    end else begin : g_noskid
      assign up_ready = (state_q == EMPTY) | bus.dn_ready_in;
    end
  endgenerate

  assign dn_valid = (state_q != EMPTY);
  assign up_fire  = bus.up_valid_in & up_ready;
  assign dn_fire  = dn_valid & bus.dn_ready_in;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush_in) begin
      // Wrong-path squash: any same-cycle accept is dropped.
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            main_d  = bus.up_data_in;
            state_d = HALF;
          end
        end
        HALF: begin
          if (up_fire && dn_fire) begin
            main_d = bus.up_data_in;
          end else if (up_fire && (SKID != 0)) begin
            skid_d  = bus.up_data_in;
            state_d = FULL;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dn_fire) begin
            main_d  = skid_q;
            state_d = HALF;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    bub_d = bub_q;
    if (bus.dn_ready_in && !dn_valid && !(&bub_q)) begin
      bub_d = bub_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      bub_q   <= bub_d;
    end
  end

  assign bus.up_ready_out   = up_ready;
  assign bus.dn_valid_out   = dn_valid;
  assign bus.dn_data_out    = dn_valid ? main_q : NOP_VALUE;
  assign bus.occupancy_out  = state_q;
  assign bus.bubble_cnt_out = bub_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table on a skid instance, scoreboard
// on skid, no-skid and narrow-counter instances sharing stimulus.
module tb_pipe_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  logic fl;
  logic uv;
  logic [31:0] ud;
  logic dr;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg_if #(.DATA_W(32), .CNT_W(16)) if1 ();
  pipe_skid_reg_if #(.DATA_W(32), .CNT_W(16)) if0 ();
  pipe_skid_reg_if #(.DATA_W(32), .CNT_W(4))  ifs ();

  pipe_skid_reg #(
    .DATA_W(32), .SKID(1), .NOP_VALUE(NOP), .CNT_W(16)
  ) u_skid (.clk_in(clk), .rst_in(rst), .bus(if1.slave));

  pipe_skid_reg #(
    .DATA_W(32), .SKID(0), .NOP_VALUE(NOP), .CNT_W(16)
  ) u_noskid (.clk_in(clk), .rst_in(rst), .bus(if0.slave));

  pipe_skid_reg #(
    .DATA_W(32), .SKID(1), .NOP_VALUE(NOP), .CNT_W(4)
  ) u_sat (.clk_in(clk), .rst_in(rst), .bus(ifs.slave));

  assign if1.flush_in = fl;
  assign if1.up_valid_in = uv;
  assign if1.up_data_in = ud;
  assign if1.dn_ready_in = dr;
  assign if0.flush_in = fl;
  assign if0.up_valid_in = uv;
  assign if0.up_data_in = ud;
  assign if0.dn_ready_in = dr;
  assign ifs.flush_in = fl;
  assign ifs.up_valid_in = uv;
  assign ifs.up_data_in = ud;
  assign ifs.dn_ready_in = dr;

  logic        v [3];
  logic [31:0] dd[3];
  logic        ur[3];
  logic [1:0]  oc[3];

  assign v[0]  = if1.dn_valid_out;
  assign dd[0] = if1.dn_data_out;
  assign ur[0] = if1.up_ready_out;
  assign oc[0] = if1.occupancy_out;
  assign v[1]  = if0.dn_valid_out;
  assign dd[1] = if0.dn_data_out;
  assign ur[1] = if0.up_ready_out;
  assign oc[1] = if0.occupancy_out;
  assign v[2]  = ifs.dn_valid_out;
  assign dd[2] = ifs.dn_data_out;
  assign ur[2] = ifs.up_ready_out;
  assign oc[2] = ifs.occupancy_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: accepted payloads per instance, popped on dn_fire.
  logic [31:0] q[3][$];

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (v[k] && dr) begin
          if (q[k].size() == 0) begin
            chk($sformatf("sb%0d_extra", k), dd[k], 32'hXXXX_XXXX);
          end else begin
            chk($sformatf("sb%0d_data", k), dd[k], q[k].pop_front());
          end
        end
        if (fl) q[k].delete();
        else if (uv && ur[k]) q[k].push_back(ud);
      end
    end
  end

  typedef struct {
    logic        chk;
    logic        r;
    logic        f;
    logic        u;
    logic [31:0] d;
    logic        dr;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        eu;
    logic [15:0] eb;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic c, logic r, logic f, logic u, logic [31:0] d, logic rd,
    logic ev, logic [31:0] ed, logic [1:0] eo, logic eu,
    logic [15:0] eb);
    vec_t t;
    t.chk = c; t.r = r; t.f = f; t.u = u; t.d = d; t.dr = rd;
    t.ev = ev; t.ed = ed; t.eo = eo; t.eu = eu; t.eb = eb;
    return t;
  endfunction

  task automatic drive(input logic r, input logic f, input logic u,
                       input logic [31:0] d, input logic rd);
    rst = r;
    fl = f;
    uv = u;
    ud = d;
    dr = rd;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fl = 1'b0; uv = 1'b0; ud = '0; dr = 1'b0;

    // reset, stream 1..8
    tv.push_back(mk(0,1,0,0,0,0, 0,NOP,0,1,0));
    tv.push_back(mk(1,1,0,0,0,0, 0,NOP,0,1,0));
    tv.push_back(mk(1,0,0,1,1,1, 0,NOP,0,1,0));
    for (int j = 2; j <= 8; j++)
      tv.push_back(mk(1,0,0,1,j,1, 1,j-1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,1, 1,8,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0, 0,NOP,0,1,1));
    // stall into skid
    tv.push_back(mk(1,0,0,1,'hA,0, 0,NOP,0,1,1));
    tv.push_back(mk(1,0,0,1,'hB,0, 1,'hA,1,1,1));
    tv.push_back(mk(1,0,0,1,'hEE,0, 1,'hA,2,0,1));
    tv.push_back(mk(1,0,0,0,0,1, 1,'hA,2,0,1));
    tv.push_back(mk(1,0,0,0,0,1, 1,'hB,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0, 0,NOP,0,1,1));
    // flush while FULL
    tv.push_back(mk(1,0,0,1,'hA,0, 0,NOP,0,1,1));
    tv.push_back(mk(1,0,0,1,'hB,0, 1,'hA,1,1,1));
    tv.push_back(mk(1,0,1,1,'hC,0, 1,'hA,2,0,1));
    tv.push_back(mk(1,0,0,0,0,1, 0,NOP,0,1,1));
    tv.push_back(mk(1,0,0,0,0,0, 0,NOP,0,1,2));
    // flush in HALF with up_fire and dn_fire
    tv.push_back(mk(1,0,0,1,'h11,0, 0,NOP,0,1,2));
    tv.push_back(mk(1,0,1,1,'h22,1, 1,'h11,1,1,2));
    tv.push_back(mk(1,0,0,0,0,0, 0,NOP,0,1,2));
    // reset while FULL, with flush and valid
    tv.push_back(mk(1,0,0,1,'hA,0, 0,NOP,0,1,2));
    tv.push_back(mk(1,0,0,1,'hB,0, 1,'hA,1,1,2));
    tv.push_back(mk(1,1,1,1,'hC,1, 1,'hA,2,0,2));
    tv.push_back(mk(1,0,0,0,0,0, 0,NOP,0,1,0));

    #1;
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].f, tv[i].u, tv[i].d, tv[i].dr);
      if (tv[i].chk) begin
        chk($sformatf("v%0d_valid", i), 32'(v[0]), 32'(tv[i].ev));
        chk($sformatf("v%0d_data", i), dd[0], tv[i].ed);
        chk($sformatf("v%0d_occ", i), 32'(oc[0]), 32'(tv[i].eo));
        chk($sformatf("v%0d_ready", i), 32'(ur[0]), 32'(tv[i].eu));
        chk($sformatf("v%0d_bub", i),
            32'(if1.bubble_cnt_out), 32'(tv[i].eb));
      end
      next_cycle();
    end

    // no-skid: ready toggling with continuous upstream data
    drive(1, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 32'h50 + i, (i % 2) == 0);
      chk($sformatf("ns%0d_occ2", i), 32'(oc[1] == 2'd2), 0);
      if (i >= 1) begin
        chk($sformatf("ns%0d_ready", i), 32'(ur[1]), 32'(dr));
        chk($sformatf("ns%0d_data", i), dd[1],
            32'h50 + 32'(2 * ((i - 1) / 2)));
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      next_cycle();
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("sb%0d_drain", k), q[k].size(), 0);

    // bubble counter saturation
    drive(1, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1);
      chk($sformatf("sat%0d", i), 32'(ifs.bubble_cnt_out),
          (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("wide%0d", i), 32'(if1.bubble_cnt_out), 32'(i));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
